move_sequencer_p: RTL and testbench
===================================

MOVE_SEQUENCER_P -- requirements
Module: move_sequencer_p

Interface
REQ-001 SHALL have parameter MOVE_W, default 4, bits per move code; code 0 is a no-op.
REQ-002 SHALL have parameter SEQ_MOVES, default 50, move slots per load word.
REQ-003 SHALL have parameter DEPTH, default 256, queue entries, power of two >= 4; PTR_W = log2(DEPTH).
REQ-004 SHALL have parameter TIMEOUT, default 2^20, maximum cycles to wait for move_done.
REQ-005 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port new_moves  in  1  one-cycle request to append seq to the queue.
REQ-008 SHALL have port seq  in  SEQ_MOVES*MOVE_W  packed moves, first move in the MSBs.
REQ-009 SHALL have port seq_complete  in  1  request to start executing the queue.
REQ-010 SHALL have port abort  in  1  stop execution and flush the queue.
REQ-011 SHALL have port move_done  in  1  executor has finished the current move.
REQ-012 SHALL have port load_busy  out  1  unpacker active; new_moves ignored while high.
REQ-013 SHALL have port next_move  out  MOVE_W  move being issued.
REQ-014 SHALL have port start_move  out  1  one-cycle strobe qualifying next_move.
REQ-015 SHALL have port seq_done  out  1  one-cycle pulse when the queue completes normally.
REQ-016 SHALL have port seq_error  out  1  sticky timeout flag, cleared by the next accepted seq_complete.
REQ-017 SHALL have port overflow  out  1  sticky flag: a non-zero move was dropped because the queue was full; cleared by abort.
REQ-018 SHALL have port num_moves  out  PTR_W+1  current queue occupancy.
REQ-019 SHALL have port curr_step  out  PTR_W+1  moves issued since the last start.

Function
REQ-020 SHALL implement the queue as a circular buffer with read and write pointers of PTR_W bits that wrap modulo DEPTH.
REQ-021 Unpacker: new_moves with load_busy low SHALL capture seq and raise load_busy on the next cycle; it SHALL examine one slot per cycle, MSB first.
REQ-022 Unpacker SHALL push only non-zero codes, and SHALL finish (load_busy low) on the cycle after the last non-zero slot is examined or after SEQ_MOVES slots, whichever is first; an all-zero seq SHALL hold load_busy high for exactly 1 cycle.
REQ-023 A push with num_moves == DEPTH SHALL drop the move and set overflow; the unpacker SHALL keep running.
REQ-024 Appending SHALL be allowed in every executor state; a push and a pop in the same cycle SHALL leave num_moves unchanged.
REQ-025 Executor states SHALL be IDLE, ISSUE, WAIT_ACK, DONE and FAULT.
REQ-026 IDLE: seq_complete with num_moves > 0 SHALL go to ISSUE and clear curr_step and seq_error; seq_complete with num_moves == 0 SHALL be ignored.
REQ-027 ISSUE (1 cycle): SHALL pop the head into next_move, pulse start_move, increment curr_step, and go to WAIT_ACK.
REQ-028 WAIT_ACK: move_done in the first cycle of WAIT_ACK SHALL be ignored.
REQ-029 WAIT_ACK: a later move_done SHALL go to ISSUE if num_moves > 0 at that cycle, otherwise to DONE.
REQ-030 WAIT_ACK: with no move_done after TIMEOUT cycles, SHALL go to FAULT.
REQ-031 DONE (1 cycle): SHALL pulse seq_done, set next_move to 0, and return to IDLE; curr_step SHALL hold its value.
REQ-032 FAULT (1 cycle): SHALL set seq_error, flush the queue (pointers equal, num_moves 0), stop the unpacker, and return to IDLE; seq_done SHALL NOT be asserted.
REQ-033 abort SHALL take priority over all other inputs in any state: next cycle is IDLE, the queue and unpacker are flushed, start_move is 0, next_move is 0, curr_step is 0, overflow is cleared, and seq_done is not asserted.
REQ-034 seq_complete outside IDLE SHALL be ignored.
REQ-035 curr_step SHALL saturate at all-ones.

Reset
REQ-036 While reset_n is low, all outputs SHALL be 0, pointers SHALL be 0, the executor SHALL be in IDLE, and the unpacker SHALL be idle; queue contents need not be cleared.
REQ-037 Asserting reset_n low mid-operation SHALL take effect immediately without a clock edge, and operation SHALL resume from IDLE on the first rising edge after release.

Verification
REQ-038 Load seq = 0x3,0x0,0x5, rest 0 -> load_busy high for 3 cycles; num_moves=2.
REQ-039 Then seq_complete, with move_done 3 cycles after each start_move -> next_move 3 then 5; start_move pulses twice; seq_done one pulse; curr_step=2.
REQ-040 DEPTH=4, load 6 non-zero moves -> num_moves=4; overflow=1; the first 4 moves are retained in order.
REQ-041 TIMEOUT=16, move_done withheld -> FAULT after 16 cycles in WAIT_ACK; seq_error=1; num_moves=0; no seq_done.
REQ-042 abort asserted in WAIT_ACK while the unpacker is active -> next cycle IDLE; num_moves=0; load_busy=0; seq_done=0.
REQ-043 Append during execution across pointer wrap (DEPTH=4, more than 8 moves total) -> all moves issued in FIFO order; push and pop in the same cycle leave num_moves unchanged.

Source files
------------

// File: rtl/move_sequencer_p.sv
`timescale 1ns/1ps
// Move sequencer: unpacks packed move words into a circular queue and
// issues them one at a time to an executor, waiting for move_done between
// moves, with a timeout fault path and an abort that flushes everything.
//
// Handshakes: new_moves is accepted only in a cycle where load_busy is low;
// start_move is a one-cycle strobe that qualifies next_move, and the executor
// answers with move_done, which is ignored in the first cycle after the strobe.
module move_sequencer_p #(
    parameter int MOVE_W    = 4,
    parameter int SEQ_MOVES = 50,
    parameter int DEPTH     = 256,
    parameter int TIMEOUT   = 2**20,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int SEQ_W    = SEQ_MOVES * MOVE_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              new_moves,
    input  logic [SEQ_W-1:0]  seq,
    input  logic              seq_complete,
    input  logic              abort,
    input  logic              move_done,
    output logic              load_busy,
    output logic [MOVE_W-1:0] next_move,
    output logic              start_move,
    output logic              seq_done,
    output logic              seq_error,
    output logic              overflow,
    output logic [PTR_W:0]    num_moves,
    output logic [PTR_W:0]    curr_step,
    output logic [2:0]        dbg_state
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_DONE     = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [TO_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [MOVE_W-1:0]   next_move_q, next_move_d;
    logic [PTR_W:0]      curr_step_q, curr_step_d;
    logic                seq_error_q, seq_error_d;
    logic                overflow_q, overflow_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic                busy_q, busy_d;
    logic [SEQ_W-1:0]    sh_q, sh_d;
    logic [MOVE_W-1:0]   mem_q [DEPTH];

    logic                flush;
    logic                pop;
    logic                push_req;
    logic                push;
    logic                full;
    logic [MOVE_W-1:0]   slot;
    logic [MOVE_W-1:0]   head;
    logic                rest_zero;

    assign flush     = abort || (state_q == S_FAULT);
    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign slot      = sh_q[SEQ_W-1 -: MOVE_W];
    assign head      = mem_q[rd_ptr_q];
    // Slots shift in from the bottom as zeros, so the "remaining slots are
    // zero" test also covers running off the end of the word.
    assign rest_zero = (sh_q[SEQ_W-MOVE_W-1:0] == '0);
    assign push      = push_req && !full;

    // Executor next-state and issue logic; abort overrides every state.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        next_move_d = next_move_q;
        curr_step_d = curr_step_q;
        seq_error_d = seq_error_q;
        pop         = 1'b0;
        if (abort) begin
            state_d     = S_IDLE;
            next_move_d = '0;
            curr_step_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (seq_complete && (count_q != '0)) begin
                        state_d     = S_ISSUE;
                        curr_step_d = '0;
                        seq_error_d = 1'b0;
                        next_move_d = head;
                    end
                end
                S_ISSUE: begin
                    pop        = 1'b1;
                    state_d    = S_WAIT_ACK;
                    wait_cnt_d = '0;
                    if (curr_step_q != '1) begin
                        curr_step_d = curr_step_q + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (move_done && (wait_cnt_q != '0)) begin
                        if (count_q != '0) begin
                            state_d     = S_ISSUE;
                            next_move_d = head;
                        end else begin
                            state_d     = S_DONE;
                            next_move_d = '0;
                        end
                    end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        state_d     = S_FAULT;
                        seq_error_d = 1'b1;
                        next_move_d = '0;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_FAULT: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Unpacker and queue bookkeeping: one slot examined per cycle, MSB first.
    always_comb begin
        busy_d     = busy_q;
        sh_d       = sh_q;
        overflow_d = overflow_q;
        push_req   = 1'b0;
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (flush) begin
            busy_d   = 1'b0;
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
            if (abort) begin
                overflow_d = 1'b0;
            end
        end else begin
            if (busy_q) begin
                push_req = (slot != '0);
                sh_d     = sh_q << MOVE_W;
                if (rest_zero) begin
                    busy_d = 1'b0;
                end
                if (push_req && full) begin
                    overflow_d = 1'b1;
                end
            end else if (new_moves) begin
                sh_d   = seq;
                busy_d = 1'b1;
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            next_move_q <= '0;
            curr_step_q <= '0;
            seq_error_q <= 1'b0;
            overflow_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            sh_q        <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            next_move_q <= next_move_d;
            curr_step_q <= curr_step_d;
            seq_error_q <= seq_error_d;
            overflow_q  <= overflow_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            sh_q        <= sh_d;
        end
    end

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= slot;
        end
    end

    assign load_busy  = busy_q;
    assign next_move  = next_move_q;
    assign start_move = (state_q == S_ISSUE) && !abort;
    assign seq_done   = (state_q == S_DONE) && !abort;
    assign seq_error  = seq_error_q;
    assign overflow   = overflow_q;
    assign num_moves  = count_q;
    assign curr_step  = curr_step_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_move_sequencer_p.sv
`timescale 1ns/1ps
// Directed bench for move_sequencer_p (small DEPTH/TIMEOUT/SEQ_MOVES build).
module tb_move_sequencer_p;

  localparam int MOVE_W    = 4;
  localparam int SEQ_MOVES = 8;
  localparam int DEPTH     = 4;
  localparam int TIMEOUT   = 16;
  localparam int PTR_W     = 2;
  localparam int SEQ_W     = SEQ_MOVES * MOVE_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_FAULT = 3'd4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic              new_moves = 1'b0;
  logic [SEQ_W-1:0]  seq = '0;
  logic              seq_complete = 1'b0;
  logic              abort = 1'b0;
  logic              move_done = 1'b0;
  logic              load_busy;
  logic [MOVE_W-1:0] next_move;
  logic              start_move;
  logic              seq_done;
  logic              seq_error;
  logic              overflow;
  logic [PTR_W:0]    num_moves;
  logic [PTR_W:0]    curr_step;
  logic [2:0]        dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int ack_cnt = 0;
  bit auto_ack = 1'b0;
  logic [MOVE_W-1:0] exp_q[$];
  logic [SEQ_W-1:0]  pairs [4];

  move_sequencer_p #(
    .MOVE_W(MOVE_W), .SEQ_MOVES(SEQ_MOVES), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .new_moves(new_moves), .seq(seq),
    .seq_complete(seq_complete), .abort(abort), .move_done(move_done),
    .load_busy(load_busy), .next_move(next_move), .start_move(start_move),
    .seq_done(seq_done), .seq_error(seq_error), .overflow(overflow),
    .num_moves(num_moves), .curr_step(curr_step), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every start_move must carry the next expected move
  always @(negedge clock) begin
    if (reset_n) begin
      if (start_move) begin
        start_cnt++;
        if (exp_q.size() == 0) check("unexpected_start_queue_size", 32'(exp_q.size()), 32'd1);
        else check("move_order", 32'(next_move), 32'(exp_q.pop_front()));
      end
      if (seq_done) done_cnt++;
    end
  end

  // executor model: move_done three cycles after each start_move
  always @(negedge clock) begin
    if (!reset_n) begin
      ack_cnt = 0;
      move_done = 1'b0;
    end else begin
      if (move_done) move_done = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) move_done = 1'b1;
      end
      if (start_move && auto_ack) ack_cnt = 3;
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic load(input logic [SEQ_W-1:0] v);
    seq = v;
    new_moves = 1'b1;
    tick();
    new_moves = 1'b0;
  endtask

  task automatic pulse_complete();
    seq_complete = 1'b1;
    tick();
    seq_complete = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic wait_unbusy(output int cycles);
    cycles = 0;
    while (load_busy && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dbg_state != ST_IDLE && n < 300) begin
      n++;
      tick();
    end
    check(tag, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    int n;
    int loads;
    int guard;
    pairs[0] = 32'h5600_0000;
    pairs[1] = 32'h7800_0000;
    pairs[2] = 32'h9A00_0000;
    pairs[3] = 32'hBC00_0000;

    // reset
    #1 reset_n = 1'b0;
    tick(2);
    check("rst_load_busy", 32'(load_busy), 0);
    check("rst_next_move", 32'(next_move), 0);
    check("rst_start_move", 32'(start_move), 0);
    check("rst_seq_done", 32'(seq_done), 0);
    check("rst_seq_error", 32'(seq_error), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_num_moves", 32'(num_moves), 0);
    check("rst_curr_step", 32'(curr_step), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    tick();

    // seq_complete with an empty queue is ignored
    pulse_complete();
    check("empty_start_ignored", 32'(dbg_state), 32'(ST_IDLE));

    // load 3,0,5
    exp_q.push_back(4'h3);
    exp_q.push_back(4'h5);
    load(32'h3050_0000);
    wait_unbusy(n);
    check("busy_cycles_305", 32'(n), 3);
    check("num_after_305", 32'(num_moves), 2);

    // execute it
    auto_ack = 1'b1;
    start_cnt = 0;
    done_cnt = 0;
    pulse_complete();
    wait_idle("t2_idle");
    check("t2_starts", 32'(start_cnt), 2);
    check("t2_done_pulses", 32'(done_cnt), 1);
    check("t2_curr_step", 32'(curr_step), 2);
    check("t2_next_move_zero", 32'(next_move), 0);
    check("t2_num_moves", 32'(num_moves), 0);

    // all-zero word
    load('0);
    wait_unbusy(n);
    check("busy_cycles_zero", 32'(n), 1);
    check("num_after_zero", 32'(num_moves), 0);

    // overflow: six moves into a four-deep queue
    for (int i = 1; i <= 4; i++) exp_q.push_back(MOVE_W'(i));
    load(32'h1234_5600);
    wait_unbusy(n);
    check("busy_cycles_ovf", 32'(n), 6);
    check("num_after_ovf", 32'(num_moves), 4);
    check("overflow_set", 32'(overflow), 1);
    start_cnt = 0;
    done_cnt = 0;
    pulse_complete();
    wait_idle("t3_idle");
    check("t3_starts", 32'(start_cnt), 4);
    check("t3_done_pulses", 32'(done_cnt), 1);
    check("overflow_sticky", 32'(overflow), 1);
    pulse_abort();
    check("overflow_cleared_by_abort", 32'(overflow), 0);

    // timeout: second move gets flushed
    auto_ack = 1'b0;
    exp_q.push_back(4'h7);
    load(32'h7800_0000);
    wait_unbusy(n);
    done_cnt = 0;
    pulse_complete();
    check("t4_in_issue", 32'(dbg_state), 32'(ST_ISSUE));
    n = 0;
    tick();
    while (dbg_state == ST_WAIT && n < 100) begin
      n++;
      tick();
    end
    check("t4_wait_cycles", 32'(n), 16);
    check("t4_fault_state", 32'(dbg_state), 32'(ST_FAULT));
    check("t4_seq_error_fault", 32'(seq_error), 1);
    tick();
    check("t4_back_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("t4_num_flushed", 32'(num_moves), 0);
    check("t4_seq_error_sticky", 32'(seq_error), 1);
    check("t4_no_seq_done", 32'(done_cnt), 0);

    // next accepted start clears seq_error
    auto_ack = 1'b1;
    exp_q.push_back(4'h2);
    load(32'h2000_0000);
    wait_unbusy(n);
    done_cnt = 0;
    pulse_complete();
    check("t4_seq_error_cleared", 32'(seq_error), 0);
    wait_idle("t4b_idle");
    check("t4b_done_pulses", 32'(done_cnt), 1);

    // abort in WAIT_ACK while the unpacker is running
    auto_ack = 1'b0;
    exp_q.push_back(4'h1);
    load(32'h1000_0000);
    wait_unbusy(n);
    pulse_complete();
    tick();
    load(32'h1111_1111);
    tick();
    check("t5_pre_busy", 32'(load_busy), 1);
    check("t5_pre_wait", 32'(dbg_state), 32'(ST_WAIT));
    done_cnt = 0;
    pulse_abort();
    check("t5_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("t5_num_zero", 32'(num_moves), 0);
    check("t5_load_busy", 32'(load_busy), 0);
    check("t5_start_move", 32'(start_move), 0);
    check("t5_next_move", 32'(next_move), 0);
    check("t5_curr_step", 32'(curr_step), 0);
    check("t5_seq_done", 32'(seq_done), 0);
    tick(3);
    check("t5_num_still_zero", 32'(num_moves), 0);
    check("t5_no_done_later", 32'(done_cnt), 0);
    pulse_complete();
    check("t5_start_after_abort_ignored", 32'(dbg_state), 32'(ST_IDLE));

    // append during execution across pointer wrap, 12 moves
    auto_ack = 1'b1;
    for (int i = 1; i <= 4; i++) exp_q.push_back(MOVE_W'(i));
    load(32'h1234_0000);
    wait_unbusy(n);
    start_cnt = 0;
    done_cnt = 0;
    pulse_complete();
    loads = 0;
    guard = 0;
    while (loads < 4 && guard < 300) begin
      if (num_moves <= 2 && !load_busy) begin
        exp_q.push_back(pairs[loads][31:28]);
        exp_q.push_back(pairs[loads][27:24]);
        load(pairs[loads]);
        loads++;
      end else begin
        tick();
      end
      guard++;
    end
    check("t6_loads", 32'(loads), 4);
    wait_idle("t6_idle");
    check("t6_starts", 32'(start_cnt), 12);
    check("t6_done_pulses", 32'(done_cnt), 1);
    check("t6_curr_step_sat", 32'(curr_step), 7);
    check("t6_no_overflow", 32'(overflow), 0);
    check("t6_num_zero", 32'(num_moves), 0);
    check("t6_scoreboard_empty", 32'(exp_q.size()), 0);

    // push and pop in the same cycle
    exp_q.push_back(4'h9);
    load(32'h9000_0000);
    wait_unbusy(n);
    start_cnt = 0;
    done_cnt = 0;
    exp_q.push_back(4'hA);
    seq = 32'hA000_0000;
    new_moves = 1'b1;
    seq_complete = 1'b1;
    tick();
    new_moves = 1'b0;
    seq_complete = 1'b0;
    check("t7_issue_busy", 32'(load_busy), 1);
    check("t7_issue_start", 32'(start_move), 1);
    check("t7_num_before", 32'(num_moves), 1);
    tick();
    check("t7_num_pushpop", 32'(num_moves), 1);
    wait_idle("t7_idle");
    check("t7_starts", 32'(start_cnt), 2);
    check("t7_done_pulses", 32'(done_cnt), 1);

    // asynchronous reset mid-operation
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h2);
    load(32'h1200_0000);
    wait_unbusy(n);
    pulse_complete();
    tick(2);
    #2 reset_n = 1'b0;
    #1;
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("arst_num", 32'(num_moves), 0);
    check("arst_curr_step", 32'(curr_step), 0);
    check("arst_next_move", 32'(next_move), 0);
    check("arst_start_move", 32'(start_move), 0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    exp_q.push_back(4'h4);
    load(32'h4000_0000);
    wait_unbusy(n);
    start_cnt = 0;
    done_cnt = 0;
    pulse_complete();
    wait_idle("arst_resume_idle");
    check("arst_resume_starts", 32'(start_cnt), 1);
    check("arst_resume_done", 32'(done_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
